instruction_issuer: RTL and testbench

- Producer side of the processor's 13-bit instruction interface.
- Accepts instruction words from a host or test sequencer over a valid/ready handshake and buffers them in a FIFO.
- Drives them one at a time onto the processor's instruction_Register input.
- Holds each word for its opcode-specific execution time, then issues the next; drives a fixed idle word whenever nothing is issuing.

---
 rtl/instruction_issuer.sv | 97 +++++++++
 tb/tb_instruction_issuer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// instruction_issuer: FIFO-buffered producer for the 13-bit instruction port;
// holds each word for its opcode's execution time and drives IDLE_WORD otherwise.
module instruction_issuer #(
   parameter int          DEPTH     = 8,
   parameter int          STORE_CYC = 1,
   parameter int          LOAD_CYC  = 1,
   parameter int          ALU_CYC   = 2,
   parameter logic [12:0] IDLE_WORD = 13'h0800
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [12:0]              in_instr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [12:0]              instruction_Register,
   output logic                     issue_valid,
   output logic                     issue_start,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int SC   = (STORE_CYC < 1) ? 1 : STORE_CYC;
   localparam int LC   = (LOAD_CYC < 1) ? 1 : LOAD_CYC;
   localparam int AC   = (ALU_CYC < 1) ? 1 : ALU_CYC;
   localparam int MAXC = (SC > LC) ? ((SC > AC) ? SC : AC) : ((LC > AC) ? LC : AC);
   localparam int HW   = $clog2(MAXC) + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state_q;
   logic [12:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q;
   logic [HW-1:0]   hold_q, hold_d;
   logic [12:0]     ir_q;
   logic            iv_q, is_q;
   logic            push, pop;
   logic [12:0]     head;

   assign in_ready = cnt_q < CW'(DEPTH);
   assign push     = in_valid & in_ready & ~flush;
   // hold_q == 0 marks the last cycle of the active word, so the next pop lands back-to-back
   assign pop      = (cnt_q != '0) & ((state_q == IDLE) | (hold_q == '0));
   assign head     = mem_q[rd_q];

   always_comb begin
      hold_d = head[12] ? HW'(AC - 1) : head[11] ? HW'(LC - 1) : HW'(SC - 1);
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= in_instr;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         ir_q    <= IDLE_WORD;
         iv_q    <= 1'b0;
         is_q    <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         // a flush drops everything behind the head, so the read pointer catches up to write
         if (flush) rd_q <= wr_q;
         else if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= flush ? '0 : cnt_q + CW'(push) - CW'(pop);
         if (pop) begin
            state_q <= ISSUE;
            ir_q    <= head;
            iv_q    <= 1'b1;
            is_q    <= 1'b1;
            hold_q  <= hold_d;
         end else begin
            is_q <= 1'b0;
            if (state_q == ISSUE) begin
               if (hold_q != '0) hold_q <= hold_q - 1'b1;
               else begin
                  state_q <= IDLE;
                  ir_q    <= IDLE_WORD;
                  iv_q    <= 1'b0;
               end
            end
         end
      end
   end

   assign instruction_Register = ir_q;
   assign issue_valid          = iv_q;
   assign issue_start          = is_q;
   assign fifo_count           = cnt_q;
   assign busy                 = iv_q | (cnt_q != '0);
endmodule

// File: tb/tb_instruction_issuer.sv
// tb_instruction_issuer: randomized and directed checks of instruction_issuer
// against a queue-plus-remaining-cycles reference model.
module tb_instruction_issuer;
   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [12:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [12:0] instruction_Register;
   logic        issue_valid;
   logic        issue_start;
   logic [3:0]  fifo_count;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   logic [12:0] mq[$];
   logic [12:0] m_cur;
   int          m_rem;
   logic        m_start;

   instruction_issuer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .instruction_Register(instruction_Register),
      .issue_valid(issue_valid), .issue_start(issue_start), .fifo_count(fifo_count),
      .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic int cyc(input logic [12:0] w);
      return w[12] ? 2 : 1;
   endfunction

   function automatic logic [20:0] dut_vec();
      return {instruction_Register, issue_valid, issue_start, fifo_count, in_ready, busy};
   endfunction

   function automatic logic [20:0] model_vec();
      logic [3:0] n;
      n = 4'(mq.size());
      return {(m_rem > 0) ? m_cur : 13'h0800, m_rem > 0, m_start, n,
              mq.size() < DEPTH, (m_rem > 0) || (mq.size() != 0)};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cur   = '0;
      m_rem   = 0;
      m_start = 1'b0;
   endtask

   // one clock: drive at negedge, advance model at posedge, settle for sampling
   task automatic step(input logic v, input logic [12:0] w, input logic f);
      bit rdy, pp, ps;
      @(negedge clock);
      in_valid = v;
      in_instr = w;
      flush    = f;
      @(posedge clock);
      rdy = mq.size() < DEPTH;
      pp  = (mq.size() > 0) && (m_rem <= 1);
      ps  = v && rdy && !f;
      if (pp) begin
         m_cur   = mq.pop_front();
         m_rem   = cyc(m_cur);
         m_start = 1'b1;
      end else begin
         m_start = 1'b0;
         if (m_rem > 0) m_rem--;
      end
      if (f) mq.delete();
      if (ps) mq.push_back(w);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; in_instr = '0;
      model_reset();
      #12;
      vectors++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL reset: dut=%h model=%h", dut_vec(), model_vec());
      end
      vectors++;
      if (instruction_Register !== 13'h0800 || in_ready !== 1'b1 || issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_const: ir=%h rdy=%b iv=%b want ir=0800 rdy=1 iv=0",
                  instruction_Register, in_ready, issue_valid);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_single();
      logic [12:0] exp_ir [4];
      logic        exp_st [4];
      exp_ir = '{13'h0800, 13'h0005, 13'h0800, 13'h0800};
      exp_st = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         step(i == 0, 13'h0005, 1'b0);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL single[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
         vectors++;
         if (instruction_Register !== exp_ir[i] || issue_start !== exp_st[i] || issue_valid !== exp_st[i]) begin
            errors++;
            $display("FAIL single_const[%0d]: ir=%h st=%b iv=%b want ir=%h st=%b",
                     i, instruction_Register, issue_start, issue_valid, exp_ir[i], exp_st[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] words  [3];
      logic [12:0] exp_ir [9];
      words  = '{13'h1000, 13'h1800, 13'h0A03};
      exp_ir = '{13'h0800, 13'h1000, 13'h1000, 13'h1800, 13'h1800, 13'h0A03,
                 13'h0800, 13'h0800, 13'h0800};
      for (int i = 0; i < 9; i++) begin
         step(i < 3, (i < 3) ? words[i] : 13'h0, 1'b0);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL b2b[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
         vectors++;
         if (instruction_Register !== exp_ir[i] || issue_start !== (i == 1 || i == 3 || i == 5)) begin
            errors++;
            $display("FAIL b2b_const[%0d]: ir=%h st=%b want ir=%h st=%b",
                     i, instruction_Register, issue_start, exp_ir[i], (i == 1 || i == 3 || i == 5));
         end
      end
   endtask

   task automatic test_fill_wrap();
      int   peak = 0;
      bit   saw_full = 0;
      logic [12:0] w;
      for (int i = 0; i < 105; i++) begin
         w = (i < 25) ? (13'h1000 | 13'(i)) : 13'($urandom);
         step(i < 45, w, 1'b0);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         if (!in_ready) saw_full = 1;
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL fill[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
      end
      vectors++;
      if (peak != DEPTH || !saw_full) begin
         errors++;
         $display("FAIL fill_peak: peak=%0d full_seen=%0d want peak=%0d full_seen=1", peak, saw_full, DEPTH);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 13; i++) begin
         step(i <= 10, 13'h1000 | 13'(i), i == 10);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL flush[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
         if (i >= 9 && i <= 11) begin
            vectors++;
            if ((i == 9  && (fifo_count !== 4'd5 || instruction_Register !== 13'h1004 || issue_start !== 1'b1)) ||
                (i == 10 && (fifo_count !== 4'd0 || instruction_Register !== 13'h1004 || issue_start !== 1'b0)) ||
                (i == 11 && (instruction_Register !== 13'h0800 || issue_valid !== 1'b0))) begin
               errors++;
               $display("FAIL flush_const[%0d]: ir=%h cnt=%0d st=%b iv=%b", i,
                        instruction_Register, fifo_count, issue_start, issue_valid);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [12:0] words [3];
      words = '{13'h1800, 13'h1001, 13'h1002};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, words[i], 1'b0);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL areset_pre[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
      end
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (instruction_Register !== 13'h0800 || issue_valid !== 1'b0 || fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL areset_now: ir=%h iv=%b cnt=%0d want ir=0800 iv=0 cnt=0",
                  instruction_Register, issue_valid, fifo_count);
      end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(i == 0, 13'h0005, 1'b0);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL areset_post[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_full_push_pop();
      logic [12:0] w;
      int          at_full = 0;
      for (int i = 0; i < 70; i++) begin
         // ALU words fill the FIFO, then store/load words force pops on consecutive edges
         w = (i < 24) ? (13'h1000 | 13'(i)) : ({1'b0, 12'($urandom)});
         step(i < 40, w, 1'b0);
         if (fifo_count == 4'd8) at_full++;
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL fullpp[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
      end
      vectors++;
      if (at_full == 0) begin
         errors++;
         $display("FAIL fullpp_reach: full cycles=%0d want >0", at_full);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 2) != 0, 13'($urandom), $urandom_range(0, 24) == 0);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_wrap();
      test_flush();
      test_async_reset();
      test_full_push_pop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
